// File: rtl/mmio_bus_bridge_pkg.sv
// mmio_pkg: shared constants, register selector and helpers for the
// MEM-stage bus bridge.
//   IO_PAGE           upper 20 address bits selecting the I/O page
//   OFS_*             word-aligned register offsets within the page
//   reg_sel_e         decoded register selector
//   be_merge()        byte-strobed update of a 32-bit word
//   decode_ofs()      page offset -> register selector (adr[1:0] ignored)
package mmio_pkg;

  localparam logic [19:0] IO_PAGE   = 20'hFFFFF;

  localparam logic [11:0] OFS_LED   = 12'h060;
  localparam logic [11:0] OFS_SW    = 12'h070;
  localparam logic [11:0] OFS_TCNT  = 12'h020;
  localparam logic [11:0] OFS_TCTL  = 12'h024;
  localparam logic [11:0] OFS_TCMP  = 12'h028;
  localparam logic [11:0] OFS_TSTAT = 12'h02C;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LED,
    REG_SW,
    REG_TCNT,
    REG_TCTL,
    REG_TCMP,
    REG_TSTAT
  } reg_sel_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  function automatic reg_sel_e decode_ofs(input logic [11:0] ofs);
    reg_sel_e sel;
    case ({ofs[11:2], 2'b00})
      OFS_LED:   sel = REG_LED;
      OFS_SW:    sel = REG_SW;
      OFS_TCNT:  sel = REG_TCNT;
      OFS_TCTL:  sel = REG_TCTL;
      OFS_TCMP:  sel = REG_TCMP;
      OFS_TSTAT: sel = REG_TSTAT;
      default:   sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_bus_bridge_if.sv
// MEM-stage data bus between the pipeline (master) and the bridge (slave).
//   adr   byte address
//   wdin  lane-aligned store data
//   we    store request
//   be    byte strobes, bit i = lane i
//   rd    combinational load data
interface mmio_bus_bridge_if;
  logic [31:0] adr;
  logic [31:0] wdin;
  logic        we;
  logic [3:0]  be;
  logic [31:0] rd;

  modport master (output adr, output wdin, output we, output be, input rd);
  modport slave  (input adr, input wdin, input we, input be, output rd);
endinterface

// File: rtl/mmio_bus_bridge_sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by a whole-vector debouncer.
// A new vector is accepted once it has been seen unchanged at s2 for
// DEB_CYC consecutive cycles.
//   clk, rst_n  clock, synchronous active-low reset
//   sw_in       raw asynchronous switch vector
//   sw_out      debounced vector
module sw_debounce #(
  parameter int          W       = 24,
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_in,
  output logic [W-1:0] sw_out
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] stable;
  logic [15:0]  cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (s1 != s2) begin
        // s2 takes a different value at this edge: restart the count
        cnt <= '0;
      end else if (cnt == DEB_CYC - 16'd1) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign sw_out = stable;

endmodule

// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: splits MEM-stage accesses between the data RAM and the
// I/O page at 0xFFFFF000 (LED register, debounced switches, 32-bit timer
// with sticky compare flag). Loads are combinational so the MEM stage
// never stalls.
//   clk, rst_n   clock, synchronous active-low reset
//   bus          MEM-stage bus (slave side)
//   ram_a/d/we/be/spo  data RAM port (async read)
//   device_sw    raw switches
//   device_led   registered LED state
module mmio_bus_bridge
  import mmio_pkg::*;
#(
  parameter int          LED_W   = 24,
  parameter int          SW_W    = 24,
  parameter logic [15:0] DEB_CYC = 16'd50000,
  parameter int          RAM_AW  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_bus_bridge_if.slave  bus,
  output logic [RAM_AW-1:0] ram_a,
  output logic [31:0]       ram_d,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_spo,
  input  logic [SW_W-1:0]   device_sw,
  output logic [LED_W-1:0]  device_led
);

  logic            io_hit;
  reg_sel_e        sel;
  logic            io_wr;
  logic [31:0]     io_rd;
  logic [31:0]     led_ext;
  logic [31:0]     led_merged;
  logic [31:0]     sw_ext;
  logic [SW_W-1:0] sw_db;
  logic [31:0]     tcnt;
  logic            tctl_en;
  logic [31:0]     tcmp;
  logic            match;
  logic            unused_bits;

  assign io_hit = (bus.adr[31:12] == IO_PAGE);
  assign sel    = decode_ofs(bus.adr[11:0]);
  assign io_wr  = bus.we & io_hit;

  assign ram_a  = bus.adr[RAM_AW+1:2];
  assign ram_d  = bus.wdin;
  assign ram_be = bus.be;
  assign ram_we = bus.we & ~io_hit;

  sw_debounce #(
    .W       (SW_W),
    .DEB_CYC (DEB_CYC)
  ) u_sw_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (device_sw),
    .sw_out (sw_db)
  );

  always_comb begin
    led_ext              = '0;
    led_ext[LED_W-1:0]   = device_led;
    sw_ext               = '0;
    sw_ext[SW_W-1:0]     = sw_db;
  end

  // Lanes above LED_W fall away when the merged word is truncated.
  assign led_merged  = be_merge(led_ext, bus.wdin, bus.be);
  assign unused_bits = ^{bus.adr[1:0], led_merged};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      device_led <= '0;
      tcnt       <= '0;
      tctl_en    <= 1'b0;
      tcmp       <= '1;
      match      <= 1'b0;
    end else begin
      if (io_wr && sel == REG_LED) begin
        device_led <= led_merged[LED_W-1:0];
      end

      // A software write replaces the increment for that cycle.
      if (io_wr && sel == REG_TCNT) begin
        tcnt <= be_merge(tcnt, bus.wdin, bus.be);
      end else if (tctl_en) begin
        tcnt <= tcnt + 32'd1;
      end

      if (io_wr && sel == REG_TCTL && bus.be[0]) begin
        tctl_en <= bus.wdin[0];
      end

      if (io_wr && sel == REG_TCMP) begin
        tcmp <= be_merge(tcmp, bus.wdin, bus.be);
      end

      // New match beats a simultaneous write-1-to-clear.
      if (tctl_en && tcnt == tcmp) begin
        match <= 1'b1;
      end else if (io_wr && sel == REG_TSTAT && bus.be[0] && bus.wdin[0]) begin
        match <= 1'b0;
      end
    end
  end

  always_comb begin
    io_rd = '0;
    case (sel)
      REG_LED:   io_rd = led_ext;
      REG_SW:    io_rd = sw_ext;
      REG_TCNT:  io_rd = tcnt;
      REG_TCTL:  io_rd = {31'd0, tctl_en};
      REG_TCMP:  io_rd = tcmp;
      REG_TSTAT: io_rd = {31'd0, match};
      default:   io_rd = '0;
    endcase
  end

  assign bus.rd = io_hit ? io_rd : ram_spo;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
module tb_mmio_bus_bridge;

  localparam int          LED_W   = 24;
  localparam int          SW_W    = 24;
  localparam int          RAM_AW  = 14;
  localparam logic [15:0] DEB_CYC = 16'd8;

  localparam logic [31:0] A_LED   = 32'hFFFFF060;
  localparam logic [31:0] A_SW    = 32'hFFFFF070;
  localparam logic [31:0] A_TCNT  = 32'hFFFFF020;
  localparam logic [31:0] A_TCTL  = 32'hFFFFF024;
  localparam logic [31:0] A_TCMP  = 32'hFFFFF028;
  localparam logic [31:0] A_TSTAT = 32'hFFFFF02C;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [RAM_AW-1:0] ram_a;
  logic [31:0]       ram_d;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_spo;
  logic [SW_W-1:0]   device_sw;
  logic [LED_W-1:0]  device_led;

  mmio_bus_bridge_if bus ();

  mmio_bus_bridge #(
    .LED_W   (LED_W),
    .SW_W    (SW_W),
    .DEB_CYC (DEB_CYC),
    .RAM_AW  (RAM_AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_spo    (ram_spo),
    .device_sw  (device_sw),
    .device_led (device_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdin;
    logic        we;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_we;
  } op_t;

  logic [31:0] exp_rd_q[$];
  logic        exp_we_q[$];
  int total = 0;
  int bad   = 0;

  function automatic op_t st(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic [31:0] e);
    op_t o;
    o.adr = a; o.wdin = d; o.we = 1'b1; o.be = b; o.exp_rd = e;
    o.exp_we = (a[31:12] != 20'hFFFFF);
    return o;
  endfunction

  function automatic op_t ld(input logic [31:0] a, input logic [31:0] e);
    op_t o;
    o.adr = a; o.wdin = 32'd0; o.we = 1'b0; o.be = 4'd0; o.exp_rd = e;
    o.exp_we = 1'b0;
    return o;
  endfunction

  task automatic idle();
    bus.adr = 32'd0; bus.wdin = 32'd0; bus.we = 1'b0; bus.be = 4'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o);
    bus.adr = o.adr; bus.wdin = o.wdin; bus.we = o.we; bus.be = o.be;
    exp_rd_q.push_back(o.exp_rd);
    exp_we_q.push_back(o.exp_we);
  endtask

  task automatic test_reset();
    op_t ops[$];
    logic [31:0] er;
    logic ew;
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    total++;
    if (device_led !== 24'd0) begin
      bad++; $display("FAIL reset_led got=%h want=%h", device_led, 24'd0);
    end
    ops.push_back(ld(A_TCNT, 32'd0));
    ops.push_back(ld(A_TCTL, 32'd0));
    ops.push_back(ld(A_TCMP, 32'hFFFFFFFF));
    ops.push_back(ld(A_TSTAT, 32'd0));
    ops.push_back(ld(A_SW, 32'd0));
    ops.push_back(ld(A_LED, 32'd0));
    foreach (ops[i]) begin
      drive(ops[i]);
      @(negedge clk);
      er = exp_rd_q.pop_front(); ew = exp_we_q.pop_front();
      total += 2;
      if (bus.rd !== er) begin bad++; $display("FAIL reset[%0d] rd got=%h want=%h", i, bus.rd, er); end
      if (ram_we !== ew) begin bad++; $display("FAIL reset[%0d] ram_we got=%b want=%b", i, ram_we, ew); end
      next_cycle();
    end
  endtask

  task automatic test_led();
    op_t ops[$];
    logic [31:0] er;
    logic ew;
    ops.push_back(st(A_LED, 32'h00AABBCC, 4'b0101, 32'd0));
    ops.push_back(ld(A_LED, 32'h00AA00CC));
    ops.push_back(st(A_LED, 32'hFF000000, 4'b1000, 32'h00AA00CC));
    ops.push_back(ld(A_LED, 32'h00AA00CC));
    ops.push_back(st(A_LED, 32'h11223344, 4'b0010, 32'h00AA00CC));
    ops.push_back(ld(A_LED, 32'h00AA33CC));
    foreach (ops[i]) begin
      drive(ops[i]);
      @(negedge clk);
      er = exp_rd_q.pop_front(); ew = exp_we_q.pop_front();
      total += 2;
      if (bus.rd !== er) begin bad++; $display("FAIL led[%0d] rd got=%h want=%h", i, bus.rd, er); end
      if (ram_we !== ew) begin bad++; $display("FAIL led[%0d] ram_we got=%b want=%b", i, ram_we, ew); end
      next_cycle();
    end
    idle();
    total++;
    if (device_led !== 24'hAA33CC) begin
      bad++; $display("FAIL led_pins got=%h want=%h", device_led, 24'hAA33CC);
    end
  endtask

  task automatic test_ram_path();
    op_t ops[$];
    logic [31:0] er;
    logic ew;
    ram_spo = 32'hCAFEF00D;
    ops.push_back(st(32'h00000104, 32'hDEADBEEF, 4'b1111, 32'hCAFEF00D));
    ops.push_back(ld(A_SW, 32'd0));
    ops.push_back(st(A_SW, 32'hFFFFFFFF, 4'b1111, 32'd0));
    ops.push_back(ld(32'h00000200, 32'hCAFEF00D));
    ops.push_back(st(32'hFFFFF100, 32'hFFFFFFFF, 4'b1111, 32'd0));
    ops.push_back(ld(32'hFFFFF100, 32'd0));
    ops.push_back(ld(32'hFFFFF064, 32'd0));
    ops.push_back(ld(32'hFFFFF063, 32'h00AA33CC));
    foreach (ops[i]) begin
      drive(ops[i]);
      @(negedge clk);
      er = exp_rd_q.pop_front(); ew = exp_we_q.pop_front();
      total += 3;
      if (bus.rd !== er) begin bad++; $display("FAIL ram[%0d] rd got=%h want=%h", i, bus.rd, er); end
      if (ram_we !== ew) begin bad++; $display("FAIL ram[%0d] ram_we got=%b want=%b", i, ram_we, ew); end
      if (ram_a !== ops[i].adr[RAM_AW+1:2]) begin
        bad++; $display("FAIL ram[%0d] ram_a got=%h want=%h", i, ram_a, ops[i].adr[RAM_AW+1:2]);
      end
      if (i == 0) begin
        total += 3;
        if (ram_a !== 14'h041) begin bad++; $display("FAIL ram_a_104 got=%h want=%h", ram_a, 14'h041); end
        if (ram_d !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_d got=%h want=%h", ram_d, 32'hDEADBEEF); end
        if (ram_be !== 4'b1111) begin bad++; $display("FAIL ram_be got=%b want=%b", ram_be, 4'b1111); end
      end
      next_cycle();
    end
    idle();
    ram_spo = 32'd0;
  endtask

  task automatic test_debounce();
    logic [31:0] er;
    logic [31:0] want;
    bus.adr = A_SW;
    device_sw = 24'h000005;
    for (int k = 0; k <= 12; k++) begin
      want = (k >= 2 + int'(DEB_CYC)) ? 32'h5 : 32'h0;
      exp_rd_q.push_back(want);
      @(negedge clk);
      er = exp_rd_q.pop_front();
      total++;
      if (bus.rd !== er) begin bad++; $display("FAIL debounce_edge[%0d] got=%h want=%h", k, bus.rd, er); end
      next_cycle();
    end
    device_sw = 24'h000003;
    for (int k = 0; k < 15; k++) begin
      if (k == 5) device_sw = 24'h000005;
      exp_rd_q.push_back(32'h5);
      @(negedge clk);
      er = exp_rd_q.pop_front();
      total++;
      if (bus.rd !== er) begin bad++; $display("FAIL debounce_glitch[%0d] got=%h want=%h", k, bus.rd, er); end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_timer_match();
    op_t ops[$];
    logic [31:0] er;
    logic ew;
    ops.push_back(st(A_TCMP, 32'd5, 4'b1111, 32'hFFFFFFFF));
    ops.push_back(st(A_TCNT, 32'd0, 4'b1111, 32'd0));
    ops.push_back(st(A_TCTL, 32'd1, 4'b1111, 32'd0));
    for (int c = 0; c <= 5; c++) ops.push_back(ld(A_TCNT, 32'(c)));
    ops.push_back(ld(A_TSTAT, 32'd1));
    ops.push_back(st(A_TSTAT, 32'd1, 4'b0001, 32'd1));
    ops.push_back(ld(A_TSTAT, 32'd0));
    ops.push_back(st(A_TCNT, 32'h0E, 4'b1111, 32'd9));
    ops.push_back(st(A_TCMP, 32'h10, 4'b1111, 32'd5));
    ops.push_back(ld(A_TCNT, 32'h0F));
    ops.push_back(st(A_TSTAT, 32'd1, 4'b0001, 32'd0));
    ops.push_back(ld(A_TSTAT, 32'd1));
    ops.push_back(st(A_TSTAT, 32'd1, 4'b0001, 32'd1));
    ops.push_back(ld(A_TSTAT, 32'd0));
    foreach (ops[i]) begin
      drive(ops[i]);
      @(negedge clk);
      er = exp_rd_q.pop_front(); ew = exp_we_q.pop_front();
      total += 2;
      if (bus.rd !== er) begin bad++; $display("FAIL timer[%0d] rd got=%h want=%h", i, bus.rd, er); end
      if (ram_we !== ew) begin bad++; $display("FAIL timer[%0d] ram_we got=%b want=%b", i, ram_we, ew); end
      next_cycle();
    end
  endtask

  // Runs straight on from test_timer_match: TCNT is 0x14 in the first cycle.
  task automatic test_wrap_priority();
    op_t ops[$];
    logic [31:0] er;
    logic ew;
    ops.push_back(st(A_TCNT, 32'hFFFFFFFF, 4'b1111, 32'h14));
    ops.push_back(ld(A_TCNT, 32'hFFFFFFFF));
    ops.push_back(ld(A_TCNT, 32'd0));
    ops.push_back(ld(A_TCNT, 32'd1));
    ops.push_back(st(A_TCNT, 32'h10, 4'b1111, 32'd2));
    ops.push_back(ld(A_TCNT, 32'h10));
    ops.push_back(ld(A_TCNT, 32'h11));
    ops.push_back(st(A_TCTL, 32'hFFFFFFFF, 4'b1111, 32'd1));
    ops.push_back(ld(A_TCTL, 32'd1));
    ops.push_back(st(A_TCMP, 32'hAABBCCDD, 4'b0110, 32'h10));
    ops.push_back(ld(A_TCMP, 32'h00BBCC10));
    foreach (ops[i]) begin
      drive(ops[i]);
      @(negedge clk);
      er = exp_rd_q.pop_front(); ew = exp_we_q.pop_front();
      total += 2;
      if (bus.rd !== er) begin bad++; $display("FAIL wrap[%0d] rd got=%h want=%h", i, bus.rd, er); end
      if (ram_we !== ew) begin bad++; $display("FAIL wrap[%0d] ram_we got=%b want=%b", i, ram_we, ew); end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    logic [31:0] er;
    logic ew;
    rst_n = 1'b0;
    bus.adr = A_LED; bus.wdin = 32'h00FFFFFF; bus.we = 1'b1; bus.be = 4'b1111;
    next_cycle();
    rst_n = 1'b1;
    idle();
    total++;
    if (device_led !== 24'd0) begin
      bad++; $display("FAIL reset_mid_led got=%h want=%h", device_led, 24'd0);
    end
    ops.push_back(ld(A_TCNT, 32'd0));
    ops.push_back(ld(A_TCNT, 32'd0));
    ops.push_back(ld(A_TCTL, 32'd0));
    ops.push_back(ld(A_TCMP, 32'hFFFFFFFF));
    ops.push_back(ld(A_TSTAT, 32'd0));
    ops.push_back(ld(A_SW, 32'd0));
    ops.push_back(ld(A_LED, 32'd0));
    foreach (ops[i]) begin
      drive(ops[i]);
      @(negedge clk);
      er = exp_rd_q.pop_front(); ew = exp_we_q.pop_front();
      total += 2;
      if (bus.rd !== er) begin bad++; $display("FAIL reset_mid[%0d] rd got=%h want=%h", i, bus.rd, er); end
      if (ram_we !== ew) begin bad++; $display("FAIL reset_mid[%0d] ram_we got=%b want=%b", i, ram_we, ew); end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    rst_n     = 1'b0;
    device_sw = '0;
    ram_spo   = 32'd0;
    idle();
    test_reset();
    test_led();
    test_ram_path();
    test_debounce();
    test_timer_match();
    test_wrap_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
